// File: rtl/song_sequencer.sv
// Beat-driven song player: three ROM songs stepped by a 4 Hz strobe, each
// note rendered as a square wave on sp, with status mirrored onto led.
module song_sequencer #(
    parameter int CLK_HZ   = 50000000,
    parameter int SONG_LEN = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_4hz,
    input  logic        play_en,
    input  logic [1:0]  sel_song,
    output logic        sp,
    output logic [4:0]  note,
    output logic        song_done,
    output logic [15:0] led
);

    // Wide enough for the lowest tone (C4) at any CLK_HZ, never below 17 bits.
    localparam int HP_CALC = $clog2(CLK_HZ / 523 + 2);
    localparam int HP_W    = (HP_CALC > 17) ? HP_CALC : 17;

    typedef logic [31:0][HP_W-1:0] half_tab_t;
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2} state_t;

    // Equal-temperament natural notes in micro-hertz, so the rounded
    // half-period divide keeps enough precision for every CLK_HZ.
    function automatic longint freq_uhz(input int c);
        case (c)
            1:  return 64'd261625565;   2:  return 64'd293664768;
            3:  return 64'd329627557;   4:  return 64'd349228231;
            5:  return 64'd391995436;   6:  return 64'd440000000;
            7:  return 64'd493883301;   8:  return 64'd523251131;
            9:  return 64'd587329536;   10: return 64'd659255114;
            11: return 64'd698456463;   12: return 64'd783990872;
            13: return 64'd880000000;   14: return 64'd987766603;
            15: return 64'd1046502261;  16: return 64'd1174659072;
            17: return 64'd1318510228;  18: return 64'd1396912926;
            19: return 64'd1567981744;  20: return 64'd1760000000;
            21: return 64'd1975533205;
            default: return 64'd1;
        endcase
    endfunction

    function automatic half_tab_t calc_half();
        half_tab_t t = '0;
        longint    f;
        for (int c = 1; c <= 21; c++) begin
            f    = freq_uhz(c);
            t[c] = HP_W'((longint'(CLK_HZ) * 64'd1000000 + f) / (2 * f));
        end
        return t;
    endfunction

    localparam half_tab_t HALF = calc_half();

    function automatic logic [4:0] rom(input logic [1:0] s, input logic [5:0] i);
        logic [4:0] c;
        c = 5'd0;
        case (s)
            2'd0: begin
                case (i)
                    6'd0: c = 5'd6;   6'd1: c = 5'd8;   6'd2: c = 5'd5;
                    6'd3: c = 5'd0;   6'd4: c = 5'd10;  6'd5: c = 5'd12;
                    6'd6: c = 5'd3;   6'd7: c = 5'd1;   6'd8: c = 5'd21;
                    6'd9: c = 5'd15;  6'd10: c = 5'd31;
                    default: c = 5'd0;
                endcase
            end
            2'd1:    c = (i[4:0] == 5'd31) ? 5'd25 : i[4:0];
            default: c = (i == 6'd40) ? 5'd31
                                      : ({2'b0, i[2:0]} + {2'b0, i[5:3]} + 5'd1);
        endcase
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      sel_q, song;
    logic [5:0]      idx_q, idx_d, idx_inc;
    logic [4:0]      note_q, note_d;
    logic            done_q, done_d;
    logic            sp_q, quiet;
    logic [HP_W-1:0] cnt_q;

    always_comb begin
        song    = (sel_q == 2'd3) ? 2'd0 : sel_q;
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        idx_inc = idx_q + 6'd1;
        case (state_q)
            IDLE:    if (play_en)  state_d = PLAY;
            PLAY:    if (!play_en) state_d = PAUSE;
            PAUSE:   if (play_en)  state_d = PLAY;
            default: state_d = IDLE;
        endcase
        // The end marker is looked up at the candidate index so it never sounds.
        if (sel_song != sel_q) begin
            idx_d = '0;
        end else if (state_q == PLAY && tick_4hz) begin
            if (idx_q == 6'(SONG_LEN - 1) || rom(song, idx_inc) == 5'd31) begin
                idx_d  = '0;
                done_d = 1'b1;
            end else begin
                idx_d = idx_inc;
            end
        end
        note_d = rom(song, idx_q);
        quiet  = (note_d != note_q) || (state_d != PLAY) ||
                 (note_d == 5'd0) || (note_d >= 5'd22);
    end

    always_ff @(posedge clk) begin
        sel_q <= sel_song;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            note_q  <= '0;
            done_q  <= 1'b0;
            sp_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            done_q  <= done_d;
            // Any new note, rest or non-playing state restarts the tone phase.
            if (quiet) begin
                cnt_q <= '0;
                sp_q  <= 1'b0;
            end else if (cnt_q == HALF[note_q] - HP_W'(1)) begin
                cnt_q <= '0;
                sp_q  <= ~sp_q;
            end else begin
                cnt_q <= cnt_q + HP_W'(1);
            end
        end
    end

    assign sp        = sp_q;
    assign note      = note_q;
    assign song_done = done_q;
    assign led       = {sp_q, song, note_q, state_q, idx_q};

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz used to derive tone half-periods.
REQ-002 SHALL have parameter SONG_LEN, default 64, maximum notes per song; the note index is 6 bits wide.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port tick_4hz, input, 1, one-clk-wide beat strobe in the clk domain, nominally every 0.25 s.
REQ-006 SHALL have port play_en, input, 1, level: 1 = play, 0 = pause.
REQ-007 SHALL have port sel_song, input, 2, song select: 0, 1 or 2; value 3 is treated as song 0.
REQ-008 SHALL have port sp, output, 1, speaker square wave.
REQ-009 SHALL have port note, output, 5, current registered note code.
REQ-010 SHALL have port song_done, output, 1, one-clk pulse at song wrap.
REQ-011 SHALL have port led, output, 16, status display.

Function
REQ-012 SHALL hold an internal ROM of 3 songs x 64 entries x 5-bit note codes; each entry lasts one beat.
REQ-013 Note codes SHALL be: 0 = rest; 1-7 = C4..B4; 8-14 = C5..B5; 15-21 = C6..B6 (naturals only); 31 = end marker; 22-30 = rest.
REQ-014 For each sounding code, the tone half-period SHALL be round(CLK_HZ/(2*f)) with equal temperament, A4 = 440 Hz; code 6 at 50 MHz gives 56818 clks.
REQ-015 SHALL implement states IDLE, PLAY and PAUSE; reset enters IDLE.
REQ-016 IDLE -> PLAY when play_en = 1; PLAY -> PAUSE when play_en = 0; PAUSE -> PLAY when play_en = 1; IDLE stays IDLE while play_en = 0.
REQ-017 In PLAY, tick_4hz = 1 SHALL increment the 6-bit note index at the next edge; ticks in IDLE and PAUSE SHALL be ignored.
REQ-018 A ROM read SHALL be registered: an index update at edge N+1 makes the note output valid at edge N+2.
REQ-019 When the fetched code is 31, or the index advances from 63, the index SHALL become 0 and song_done SHALL pulse for exactly 1 clk.
REQ-020 Any change of sel_song (registered compare) SHALL reset the index to 0 in any state; this takes priority over a simultaneous tick.
REQ-021 The tone counter SHALL reload and sp SHALL be forced to 0 whenever note changes; sp then toggles every half-period clks.
REQ-022 sp SHALL be 0 in IDLE, in PAUSE, and for rest codes.
REQ-023 PAUSE SHALL preserve the index; resuming continues from the same note with the tone phase restarted.
REQ-024 led SHALL be: [15] = sp, [14:13] = effective song, [12:8] = note, [7:6] = state (IDLE = 0, PLAY = 1, PAUSE = 2), [5:0] = index.
REQ-025 The half-period counter SHALL be 17 bits wide minimum, sufficient for C4 at CLK_HZ (95557 at 50 MHz).

Reset
REQ-026 While reset = 0 at a clk edge: state = IDLE, index = 0, note = 0, sp = 0, song_done = 0, led = 0 next cycle except led[14:13] = effective song.
REQ-027 Reset asserted mid-note SHALL abort the tone within 1 clk; no ROM contents are affected.
REQ-028 After reset release, the first tick SHALL NOT advance the index unless play_en was already 1 on the preceding edge (IDLE -> PLAY takes 1 clk).

Verification
REQ-029 Reset, play_en = 1, song 0 with ROM[0] = 6: sp period = 113636 clks; led[7:6] = 1; index = 0.
REQ-030 In PLAY, pulse tick_4hz at cycle N: index = 1 at N+1, note = ROM[1] at N+2, sp = 0 at N+2 and first toggles at N+2+halfperiod.
REQ-031 With ROM entry 10 = 31: after the 10th tick, index = 0, song_done high for 1 clk, note = ROM[0] 2 clks later.
REQ-032 Drop play_en at index 5: sp = 0, led[7:6] = 2; 3 ticks are ignored; raise play_en: index still 5, tone resumes.
REQ-033 Change sel_song 0 -> 2 in the same cycle as a tick at index 7: index = 0, led[14:13] = 2; sel_song = 3 gives led[14:13] = 0.
REQ-034 Assert reset for 1 clk mid-tone at index 20: next cycle sp = 0, index = 0, state IDLE, song_done = 0.
